// File: rtl/vga_timing_decoder.sv
// VGA timing decoder: turns free-running H/V pixel counts into registered sync,
// video window, coordinates and strobes, gated by a counter-sequencing lock monitor.
module vga_timing_decoder #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 29,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic [15:0] H_Count_Value,
    input  logic [15:0] V_Count_Value,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        seq_error,
    output logic [7:0]  error_count
);

    localparam logic [15:0] H_TOTAL   = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [15:0] V_TOTAL   = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [15:0] H_VIS_END = 16'(H_VISIBLE);
    localparam logic [15:0] V_VIS_END = 16'(V_VISIBLE);
    localparam logic [15:0] HS_START  = 16'(H_VISIBLE + H_FRONT);
    localparam logic [15:0] HS_END    = 16'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [15:0] VS_START  = 16'(V_VISIBLE + V_FRONT);
    localparam logic [15:0] VS_END    = 16'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_prev_vld_p1;
    logic [15:0] r_h_p1;
    logic [15:0] r_v_p1;

    logic        w_h_wrap;
    logic [15:0] w_exp_h;
    logic [15:0] w_exp_v;
    logic        w_mismatch;
    logic        w_origin;
    logic        w_visible;
    logic        w_hsync_on;
    logic        w_vsync_on;
    logic        w_err;
    logic        w_video_on;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Expected-next counts: V only advances on the edge where H wraps.
    assign w_h_wrap = (r_h_p1 == H_TOTAL - 16'd1);
    assign w_exp_h  = w_h_wrap ? 16'd0 : r_h_p1 + 16'd1;
    assign w_exp_v  = !w_h_wrap ? r_v_p1 :
                      (r_v_p1 == V_TOTAL - 16'd1) ? 16'd0 : r_v_p1 + 16'd1;

    assign w_mismatch = r_prev_vld_p1 &&
                        ((H_Count_Value != w_exp_h) || (V_Count_Value != w_exp_v) ||
                         (H_Count_Value >= H_TOTAL) || (V_Count_Value >= V_TOTAL));

    assign w_origin   = (H_Count_Value == 16'd0) && (V_Count_Value == 16'd0);
    assign w_visible  = (H_Count_Value < H_VIS_END) && (V_Count_Value < V_VIS_END);
    assign w_hsync_on = (H_Count_Value >= HS_START) && (H_Count_Value < HS_END);
    assign w_vsync_on = (V_Count_Value >= VS_START) && (V_Count_Value < VS_END);

    always_comb begin
        w_next_state = r_state;
        w_err        = 1'b0;
        unique case (r_state)
            ST_SEARCH: begin
                if (w_origin) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_mismatch) begin
                    w_err        = 1'b1;
                    w_next_state = ST_SEARCH;
                end else if (w_origin) begin
                    w_next_state = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_mismatch) begin
                    w_err        = 1'b1;
                    w_next_state = ST_SEARCH;
                end
            end
            default: w_next_state = ST_SEARCH;
        endcase
    end

    // The window opens only on samples that leave the monitor in LOCKED.
    assign w_video_on = w_visible && (w_next_state == ST_LOCKED);

    // Stage p1: registered outputs and control state.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            r_state       <= ST_SEARCH;
            r_prev_vld_p1 <= 1'b0;
            hsync         <= ~SYNC_ACTIVE;
            vsync         <= ~SYNC_ACTIVE;
            video_on      <= 1'b0;
            pixel_x       <= 10'd0;
            pixel_y       <= 10'd0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            locked        <= 1'b0;
            seq_error     <= 1'b0;
            error_count   <= 8'd0;
        end else begin
            r_state       <= w_next_state;
            r_prev_vld_p1 <= 1'b1;
            hsync         <= w_hsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync         <= w_vsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on      <= w_video_on;
            pixel_x       <= w_video_on ? H_Count_Value[9:0] : 10'd0;
            pixel_y       <= w_video_on ? V_Count_Value[9:0] : 10'd0;
            line_start    <= (H_Count_Value == 16'd0);
            frame_start   <= w_origin;
            locked        <= (w_next_state == ST_LOCKED);
            seq_error     <= w_err;
            error_count   <= w_err ? sat_inc(error_count) : error_count;
        end
    end

    // Previous-sample history; qualified by r_prev_vld_p1, so it needs no reset.
    always_ff @(posedge clk_25MHz) begin
        r_h_p1 <= H_Count_Value;
        r_v_p1 <= V_Count_Value;
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench: full-size instance for decode/range checks, reduced-geometry
// instance (8x6 frame) for lock, recovery, saturation and mid-run reset.
module tb_vga_timing_decoder;

    localparam int HT_B = 8;
    localparam int VT_B = 6;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [15:0] ha, va, hb, vb;

    logic       a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
    logic       a_locked, a_seq_error;
    logic [9:0] a_pixel_x, a_pixel_y;
    logic [7:0] a_error_count;

    logic       b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
    logic       b_locked, b_seq_error;
    logic [9:0] b_pixel_x, b_pixel_y;
    logic [7:0] b_error_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_decoder u_dut (
        .clk_25MHz     (clk),
        .reset         (rst_a),
        .H_Count_Value (ha),
        .V_Count_Value (va),
        .hsync         (a_hsync),
        .vsync         (a_vsync),
        .video_on      (a_video_on),
        .pixel_x       (a_pixel_x),
        .pixel_y       (a_pixel_y),
        .line_start    (a_line_start),
        .frame_start   (a_frame_start),
        .locked        (a_locked),
        .seq_error     (a_seq_error),
        .error_count   (a_error_count)
    );

    vga_timing_decoder #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .clk_25MHz     (clk),
        .reset         (rst_b),
        .H_Count_Value (hb),
        .V_Count_Value (vb),
        .hsync         (b_hsync),
        .vsync         (b_vsync),
        .video_on      (b_video_on),
        .pixel_x       (b_pixel_x),
        .pixel_y       (b_pixel_y),
        .line_start    (b_line_start),
        .frame_start   (b_frame_start),
        .locked        (b_locked),
        .seq_error     (b_seq_error),
        .error_count   (b_error_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a sample, let the active edge take it, then look 1 time unit later.
    task automatic tick_a(input int h, input int v);
        ha = 16'(h);
        va = 16'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic tick_b(input int h, input int v);
        hb = 16'(h);
        vb = 16'(v);
        @(posedge clk);
        #1;
    endtask

    // Clean ideal sequence on the small instance over linear frame positions i0..i1.
    task automatic run_b(input int i0, input int i1);
        for (int idx = i0; idx <= i1; idx++) begin
            tick_b(idx % HT_B, idx / HT_B);
            chk("run_b_seq_error", 32'(b_seq_error), 32'd0);
        end
    endtask

    initial begin
        int n0;
        logic el, vis;
        logic [7:0] exp_cnt;

        rst_a = 1'b1; rst_b = 1'b1;
        ha = 16'd700; va = 16'd495; hb = 16'd0; vb = 16'd0;

        // Reset values under counts that would otherwise assert hsync
        repeat (3) tick_a(700, 495);
        chk("rst_hsync",       32'(a_hsync),       32'd1);
        chk("rst_vsync",       32'(a_vsync),       32'd1);
        chk("rst_video_on",    32'(a_video_on),    32'd0);
        chk("rst_pixel_x",     32'(a_pixel_x),     32'd0);
        chk("rst_pixel_y",     32'(a_pixel_y),     32'd0);
        chk("rst_line_start",  32'(a_line_start),  32'd0);
        chk("rst_frame_start", 32'(a_frame_start), 32'd0);
        chk("rst_locked",      32'(a_locked),      32'd0);
        chk("rst_seq_error",   32'(a_seq_error),   32'd0);
        chk("rst_error_count", 32'(a_error_count), 32'd0);

        // Ideal sequence from origin: hsync decode across lines 0 and 1
        rst_a = 1'b0;
        tick_a(0, 0);
        chk("org_line_start",  32'(a_line_start),  32'd1);
        chk("org_frame_start", 32'(a_frame_start), 32'd1);
        chk("org_locked",      32'(a_locked),      32'd0);
        chk("org_video_on",    32'(a_video_on),    32'd0);
        for (int v = 0; v <= 1; v++) begin
            for (int h = (v == 0) ? 1 : 0; h < 800; h++) begin
                tick_a(h, v);
                chk("hs_decode", 32'(a_hsync), (h >= 656 && h < 752) ? 32'd0 : 32'd1);
                chk("hs_seq_error", 32'(a_seq_error), 32'd0);
                if (h == 0) begin
                    chk("l1_line_start",  32'(a_line_start),  32'd1);
                    chk("l1_frame_start", 32'(a_frame_start), 32'd0);
                end
                if (h == 1) chk("h1_line_start", 32'(a_line_start), 32'd0);
            end
        end
        // H = 800 after 799 in CHECK: out of range and wrong successor
        tick_a(800, 1);
        chk("h800_seq_error",   32'(a_seq_error),   32'd1);
        chk("h800_error_count", 32'(a_error_count), 32'd1);
        chk("h800_locked",      32'(a_locked),      32'd0);
        tick_a(801, 1);
        chk("h801_seq_error",   32'(a_seq_error),   32'd0);
        chk("h801_error_count", 32'(a_error_count), 32'd1);
        // V advancing without an H wrap
        tick_a(0, 0);
        tick_a(1, 0);
        chk("vadv_pre_seq_error", 32'(a_seq_error), 32'd0);
        tick_a(2, 1);
        chk("vadv_seq_error",   32'(a_seq_error),   32'd1);
        chk("vadv_error_count", 32'(a_error_count), 32'd2);
        tick_a(3, 1);
        chk("vadv_post_seq_error", 32'(a_seq_error), 32'd0);

        // vsync decode around lines 488..492
        rst_a = 1'b1;
        tick_a(700, 488);
        chk("rst2_error_count", 32'(a_error_count), 32'd0);
        rst_a = 1'b0;
        for (int v = 488; v <= 492; v++) begin
            for (int h = (v == 488) ? 701 : 0; h < 800; h++) begin
                tick_a(h, v);
                chk("vs_decode", 32'(a_vsync), (v == 490 || v == 491) ? 32'd0 : 32'd1);
                chk("vs_hsync",  32'(a_hsync), (h >= 656 && h < 752) ? 32'd0 : 32'd1);
            end
        end

        // Frame wrap 799/520 -> 0/0
        rst_a = 1'b1;
        tick_a(798, 520);
        rst_a = 1'b0;
        tick_a(799, 520);
        chk("wrap_pre_frame_start", 32'(a_frame_start), 32'd0);
        tick_a(0, 0);
        chk("wrap_frame_start", 32'(a_frame_start), 32'd1);
        chk("wrap_seq_error",   32'(a_seq_error),   32'd0);
        tick_a(1, 0);
        chk("wrap_post_frame_start", 32'(a_frame_start), 32'd0);
        rst_a = 1'b1;

        // Lock acquisition on the small instance, three clean frames
        tick_b(0, 0);
        rst_b = 1'b0;
        n0 = 0;
        for (int f = 0; f < 3; f++) begin
            for (int v = 0; v < VT_B; v++) begin
                for (int h = 0; h < HT_B; h++) begin
                    tick_b(h, v);
                    if (h == 0 && v == 0) n0++;
                    el  = (n0 >= 2);
                    vis = (h < 4) && (v < 3);
                    chk("lk_locked",   32'(b_locked),   32'(el));
                    chk("lk_video_on", 32'(b_video_on), 32'(el && vis));
                    chk("lk_pixel_x",  32'(b_pixel_x),  (el && vis) ? 32'(h) : 32'd0);
                    chk("lk_pixel_y",  32'(b_pixel_y),  (el && vis) ? 32'(v) : 32'd0);
                    chk("lk_hsync",    32'(b_hsync),    (h == 5 || h == 6) ? 32'd0 : 32'd1);
                    chk("lk_vsync",    32'(b_vsync),    (v == 4) ? 32'd0 : 32'd1);
                    chk("lk_seq_error", 32'(b_seq_error), 32'd0);
                end
            end
        end

        // Error recovery: jump H from 1 to 3 while locked
        tick_b(0, 0);
        run_b(1, 9);
        chk("rec_pre_video_on", 32'(b_video_on), 32'd1);
        chk("rec_pre_pixel_x",  32'(b_pixel_x),  32'd1);
        chk("rec_pre_pixel_y",  32'(b_pixel_y),  32'd1);
        tick_b(3, 1);
        chk("rec_seq_error",   32'(b_seq_error),   32'd1);
        chk("rec_error_count", 32'(b_error_count), 32'd1);
        chk("rec_locked",      32'(b_locked),      32'd0);
        chk("rec_video_on",    32'(b_video_on),    32'd0);
        chk("rec_pixel_x",     32'(b_pixel_x),     32'd0);
        tick_b(4, 1);
        chk("rec_pulse_end",   32'(b_seq_error),   32'd0);
        chk("rec_count_hold",  32'(b_error_count), 32'd1);
        run_b(13, 47);
        tick_b(0, 0);
        chk("rec_check_locked", 32'(b_locked), 32'd0);
        run_b(1, 47);
        tick_b(0, 0);
        chk("rec_relock",          32'(b_locked),   32'd1);
        chk("rec_relock_video_on", 32'(b_video_on), 32'd1);

        // 300 violations, each from LOCKED, relocking in between
        exp_cnt = 8'd1;
        for (int i = 0; i < 300; i++) begin
            tick_b(2, 0);
            exp_cnt = (exp_cnt == 8'd255) ? exp_cnt : exp_cnt + 8'd1;
            chk("sat_seq_error",   32'(b_seq_error),   32'd1);
            chk("sat_error_count", 32'(b_error_count), 32'(exp_cnt));
            chk("sat_locked",      32'(b_locked),      32'd0);
            tick_b(0, 0);
            chk("sat_search_quiet", 32'(b_seq_error), 32'd0);
            run_b(1, 47);
            tick_b(0, 0);
            chk("sat_relock", 32'(b_locked), 32'd1);
        end
        chk("sat_final", 32'(b_error_count), 32'd255);

        // Mid-line reset while locked and visible
        tick_b(1, 0);
        tick_b(2, 0);
        chk("mid_pre_video_on", 32'(b_video_on), 32'd1);
        rst_b = 1'b1;
        tick_b(3, 0);
        chk("mid_error_count", 32'(b_error_count), 32'd0);
        chk("mid_locked",      32'(b_locked),      32'd0);
        chk("mid_video_on",    32'(b_video_on),    32'd0);
        chk("mid_pixel_x",     32'(b_pixel_x),     32'd0);
        chk("mid_hsync",       32'(b_hsync),       32'd1);
        chk("mid_seq_error",   32'(b_seq_error),   32'd0);
        rst_b = 1'b0;
        tick_b(4, 0);
        chk("mid_post_locked",    32'(b_locked),    32'd0);
        chk("mid_post_seq_error", 32'(b_seq_error), 32'd0);
        run_b(5, 47);
        tick_b(0, 0);
        chk("mid_search_to_check", 32'(b_locked), 32'd0);

        // Mismatch landing on H = 0, V = 0 while in CHECK
        run_b(1, 19);
        tick_b(0, 0);
        chk("sim_seq_error",   32'(b_seq_error),   32'd1);
        chk("sim_error_count", 32'(b_error_count), 32'd1);
        chk("sim_frame_start", 32'(b_frame_start), 32'd1);
        chk("sim_locked",      32'(b_locked),      32'd0);
        run_b(1, 47);
        tick_b(0, 0);
        chk("sim_not_locked", 32'(b_locked), 32'd0);
        run_b(1, 47);
        tick_b(0, 0);
        chk("sim_relock", 32'(b_locked), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
